// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - mode encoding shared by the tff_bank slice
package tff_pkg;

  typedef enum logic [1:0] {
    MODE_TOG = 2'b00,
    MODE_UP  = 2'b01,
    MODE_DN  = 2'b10,
    MODE_SR  = 2'b11
  } mode_e;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with set/clear and async active-low reset
// Set has priority over clear, and clear over toggle; the bank keeps them mutually exclusive.
module tff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tog,
  input  logic i_set,
  input  logic i_clr,
  output logic o_q,
  output logic o_q_bar
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_q <= RST_VAL;
    end else if (i_set) begin
      r_q <= 1'b1;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end else if (i_tog) begin
      r_q <= ~r_q;
    end
  end

  assign o_q     = r_q;
  assign o_q_bar = ~r_q;

endmodule

// File: rtl/tff_bank.sv
// rtl/tff_bank.sv - WIDTH-bit T flip-flop bank: toggle, up/down counter and SR modes
// Optional TFF_BANK_TEDGE_EN: TOG mode toggles only on a rising edge of each t bit.
module tff_bank
  import tff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_t,
  input  logic [WIDTH-1:0] i_clr,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_bar,
  output logic             o_tc,
  output logic             o_err
);

  mode_e            w_mode;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_bar;
  logic [WIDTH-1:0] w_tog_src;
  logic [WIDTH-1:0] w_ones_below;
  logic [WIDTH-1:0] w_zeros_below;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wrap;
  logic             w_conflict;
  logic             r_tc;
  logic             r_err;

  assign w_mode = mode_e'(i_mode);

`ifdef TFF_BANK_TEDGE_EN
  logic [WIDTH-1:0] r_t_d;

  // Tracks t every cycle, independent of en and mode, so edges are seen relative to the last clock.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_t_d <= '0;
    end else begin
      r_t_d <= i_t;
    end
  end

  assign w_tog_src = i_t & ~r_t_d;
`else
  assign w_tog_src = i_t;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    if (i == 0) begin : g_lsb
      assign w_ones_below[i]  = 1'b1;
      assign w_zeros_below[i] = 1'b1;
    end else begin : g_upper
      assign w_ones_below[i]  = &w_q[i-1:0];
      assign w_zeros_below[i] = ~|w_q[i-1:0];
    end
  end

  always_comb begin
    w_tog = '0;
    w_set = '0;
    w_clr = '0;
    if (i_en) begin
      case (w_mode)
        MODE_TOG: w_tog = w_tog_src;
        MODE_UP:  w_tog = w_ones_below;
        MODE_DN:  w_tog = w_zeros_below;
        MODE_SR: begin
          w_set = i_t & ~i_clr;
          w_clr = i_clr & ~i_t;
        end
        default: ;
      endcase
    end
  end

  assign w_wrap     = i_en & (((w_mode == MODE_UP) & (&w_q)) | ((w_mode == MODE_DN) & ~(|w_q)));
  assign w_conflict = i_en & (w_mode == MODE_SR) & (|(i_t & i_clr));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tc  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_tc <= w_wrap;
      if (w_conflict) begin
        r_err <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(
      .RST_VAL(RST_VAL[i])
    ) u_cell (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_tog   (w_tog[i]),
      .i_set   (w_set[i]),
      .i_clr   (w_clr[i]),
      .o_q     (w_q[i]),
      .o_q_bar (w_q_bar[i])
    );
  end

  assign o_q     = w_q;
  assign o_q_bar = w_q_bar;
  assign o_tc    = r_tc;
  assign o_err   = r_err;

endmodule

// File: tb/tb_tff_bank.sv
// tb/tb_tff_bank.sv - scoreboard bench for tff_bank (WIDTH=4, RST_VAL=0), TFF_BANK_TEDGE_EN aware
module tb_tff_bank;
  import tff_pkg::*;

  localparam int               WIDTH   = 4;
  localparam logic [WIDTH-1:0] RST_VAL = '0;
`ifdef TFF_BANK_TEDGE_EN
  localparam bit TEDGE = 1'b1;
`else
  localparam bit TEDGE = 1'b0;
`endif

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       err;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_en = 1'b0;
  logic [1:0] i_mode = 2'b00;
  logic [3:0] i_t = '0;
  logic [3:0] i_clr = '0;
  logic [3:0] o_q;
  logic [3:0] o_q_bar;
  logic       o_tc;
  logic       o_err;

  exp_t sb[$];
  event ev_chk;
  int   n_checks = 0;
  int   n_fail = 0;

  int         m_q;
  bit         m_err;
  logic [3:0] m_td;

  tff_bank #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_mode  (i_mode),
    .i_t     (i_t),
    .i_clr   (i_clr),
    .o_q     (o_q),
    .o_q_bar (o_q_bar),
    .o_tc    (o_tc),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares whatever is pending after each clock edge or async-reset notification.
  initial begin : monitor
    exp_t e;
    logic [3:0] nq;
    forever begin
      @(posedge clk or ev_chk);
      #1;
      while (sb.size() > 0) begin
        e  = sb.pop_front();
        nq = ~e.q;
        chk({e.tag, " q"}, o_q, e.q);
        chk({e.tag, " q_bar"}, o_q_bar, nq);
        chk({e.tag, " tc"}, {3'b0, o_tc}, {3'b0, e.tc});
        chk({e.tag, " err"}, {3'b0, o_err}, {3'b0, e.err});
      end
    end
  end

  // Called at a negedge; drives inputs, predicts the state after the next rising edge.
  task automatic step(input bit en, input logic [1:0] mode, input logic [3:0] t,
                      input logic [3:0] clr, input string tag);
    int         nq;
    logic       tc;
    logic [3:0] tv;
    exp_t       e;
    i_en = en; i_mode = mode; i_t = t; i_clr = clr;
    nq = m_q;
    tc = 1'b0;
    if (en) begin
      case (mode)
        2'b00: begin
          tv = TEDGE ? (t & ~m_td) : t;
          nq = m_q ^ int'(tv);
        end
        2'b01: begin
          nq = (m_q + 1) % 16;
          tc = (nq == 0);
        end
        2'b10: begin
          nq = (m_q + 15) % 16;
          tc = (nq == 15);
        end
        default: begin
          for (int b = 0; b < 4; b++) begin
            case ({t[b], clr[b]})
              2'b10: nq = nq | (1 << b);
              2'b01: nq = nq & ~(1 << b);
              2'b11: m_err = 1'b1;
              default: ;
            endcase
          end
        end
      endcase
    end
    m_td = t;
    m_q  = nq;
    e.q = nq[3:0]; e.tc = tc; e.err = m_err; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Called at a negedge; asserts reset between edges and has it checked before the next edge.
  task automatic do_reset(input string tag);
    exp_t e;
    #2;
    i_rst = 1'b0;
    m_q = int'(RST_VAL); m_err = 1'b0; m_td = '0;
    e.q = RST_VAL; e.tc = 1'b0; e.err = 1'b0; e.tag = tag;
    sb.push_back(e);
    ->ev_chk;
    @(negedge clk);
    i_rst = 1'b1;
  endtask

  initial begin : stim
    exp_t e;
    m_q = int'(RST_VAL); m_err = 1'b0; m_td = '0;
    #2;
    e.q = RST_VAL; e.tc = 1'b0; e.err = 1'b0; e.tag = "por";
    sb.push_back(e);
    ->ev_chk;
    @(negedge clk);
    i_rst = 1'b1;

    for (int k = 0; k < 6; k++) step(1'b1, MODE_UP, 4'($urandom), 4'($urandom), "up6");
    do_reset("rst_mid");

    for (int k = 0; k < 3; k++) step(1'b1, MODE_TOG, 4'b0101, 4'b0000, "tog");
    do_reset("rst2");

    for (int k = 0; k < 16; k++) step(1'b1, MODE_UP, 4'($urandom), 4'($urandom), "up16");
    do_reset("rst3");

    for (int k = 0; k < 2; k++) step(1'b1, MODE_DN, 4'($urandom), 4'($urandom), "dn");
    do_reset("rst4");

    step(1'b1, MODE_SR, 4'b0011, 4'b0000, "sr_load");
    step(1'b1, MODE_SR, 4'b1000, 4'b0001, "sr_setclr");
    step(1'b1, MODE_SR, 4'b0100, 4'b0100, "sr_conflict");
    for (int k = 0; k < 4; k++) step(1'b1, MODE_TOG, 4'($urandom), 4'b0000, "err_sticky");
    for (int k = 0; k < 8; k++) step(1'b0, 2'(k % 4), 4'($urandom), 4'($urandom), "hold_err");
    do_reset("rst5");

    for (int k = 0; k < 3; k++) step(1'b1, MODE_UP, 4'b0000, 4'b0000, "pre_hold");
    for (int k = 0; k < 8; k++) step(1'b0, 2'(k % 4), 4'b1111, 4'b1111, "hold");
    step(1'b1, MODE_DN, 4'b1111, 4'b1111, "dn_conflict");

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
      step($urandom_range(0, 7) != 0, 2'($urandom), 4'($urandom), 4'($urandom), "rnd");
    end

    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
